// File: rtl/pixel_window_ctrl.sv
// Pixel window hit detector: NWIN shadow/active rectangular windows, fixed-priority
// selection and a per-window frame-buffer read-address counter, one-cycle latency.
module pixel_window_ctrl #(
  parameter int W    = 10,
  parameter int NWIN = 2,
  parameter int AW   = 17,
  parameter int IW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [W-1:0]  cfg_xl,
  input  logic [W-1:0]  cfg_xr,
  input  logic [W-1:0]  cfg_yu,
  input  logic [W-1:0]  cfg_yd,
  input  logic          cfg_en,
  output logic          read_pixel,
  output logic [IW-1:0] win_id,
  output logic [AW-1:0] rd_addr,
  output logic          cfg_pending
);

  typedef struct packed {
    logic [W-1:0] xl;
    logic [W-1:0] xr;
    logic [W-1:0] yu;
    logic [W-1:0] yd;
    logic         en;
  } winCfgT;

  // One extra bit so the limit is representable even when NWIN == 2**IW.
  localparam logic [IW:0] NWIN_LIM = (IW+1)'(NWIN);

  winCfgT          shadowWin [NWIN];
  winCfgT          activeWin [NWIN];
  logic [AW-1:0]   addrCnt   [NWIN];

  winCfgT          cfgWord;
  logic            cfgAccept;
  logic [NWIN-1:0] cfgSel;
  logic [NWIN-1:0] winHit;
  logic [NWIN-1:0] grant;
  logic            hitAny;
  logic [IW-1:0]   hitId;
  logic [AW-1:0]   hitAddr;

  assign cfgWord   = {cfg_xl, cfg_xr, cfg_yu, cfg_yd, cfg_en};
  assign cfgAccept = cfg_we && ({1'b0, cfg_idx} < NWIN_LIM);

  // Inverted bounds can never satisfy both compares, so they need no special case.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cfgSel  = '0;
    winHit  = '0;
    grant   = '0;
    hitAny  = 1'b0;
    hitId   = '0;
    hitAddr = '0;
    for (int k = 0; k < NWIN; k++) begin
      cfgSel[k] = cfgAccept && (cfg_idx == IW'(k));
      winHit[k] = pix_valid && activeWin[k].en &&
                  (x >= activeWin[k].xl) && (x <= activeWin[k].xr) &&
                  (y >= activeWin[k].yu) && (y <= activeWin[k].yd);
      if (winHit[k] && !hitAny) begin
        hitAny   = 1'b1;
        grant[k] = 1'b1;
        hitId    = IW'(k);
        hitAddr  = addrCnt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: window arrays are reset explicitly; an unknown enable would allow stray hits.
      for (int k = 0; k < NWIN; k++) begin
        shadowWin[k] <= '0;
        activeWin[k] <= '0;
        addrCnt[k]   <= '0;
      end
      read_pixel  <= 1'b0;
      win_id      <= '0;
      rd_addr     <= '0;
      cfg_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int k = 0; k < NWIN; k++) begin
        if (cfgSel[k]) shadowWin[k] <= cfgWord;
        // A write on the frame_start edge goes straight through to the active copy.
        if (frame_start) activeWin[k] <= cfgSel[k] ? cfgWord : shadowWin[k];
        if (frame_start)   addrCnt[k] <= '0;
        else if (grant[k]) addrCnt[k] <= addrCnt[k] + AW'(1);
      end
      if (frame_start)    cfg_pending <= 1'b0;
      else if (cfgAccept) cfg_pending <= 1'b1;
      read_pixel <= hitAny;
      win_id     <= hitId;
      rd_addr    <= hitAddr;
    end
  end

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Scoreboard bench for pixel_window_ctrl: stimulus queues expected hits, negedge
// monitors pop and compare; a second AW=4 instance covers counter wrap.
module tb_pixel_window_ctrl;

  localparam int W    = 10;
  localparam int NWIN = 2;
  localparam int AW   = 17;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          rst_n, rst4_n;
  logic          frame_start, pix_valid, cfg_we, cfg_en;
  logic [W-1:0]  x, y, cfg_xl, cfg_xr, cfg_yu, cfg_yd;
  logic [IW-1:0] cfg_idx;

  logic          read_pixel, cfg_pending;
  logic [IW-1:0] win_id;
  logic [AW-1:0] rd_addr;
  logic          read_pixel4, cfg_pending4;
  logic [IW-1:0] win_id4;
  logic [3:0]    rd_addr4;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } expT;

  expT q[$];
  expT q4[$];
  bit  aw4Phase = 1'b0;
  int  total = 0;
  int  bad   = 0;

  pixel_window_ctrl #(.W(W), .NWIN(NWIN), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_xl(cfg_xl), .cfg_xr(cfg_xr), .cfg_yu(cfg_yu), .cfg_yd(cfg_yd), .cfg_en(cfg_en),
    .read_pixel(read_pixel), .win_id(win_id), .rd_addr(rd_addr), .cfg_pending(cfg_pending)
  );

  pixel_window_ctrl #(.W(W), .NWIN(NWIN), .AW(4), .IW(IW)) dut4 (
    .clk(clk), .rst_n(rst4_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_xl(cfg_xl), .cfg_xr(cfg_xr), .cfg_yu(cfg_yu), .cfg_yd(cfg_yd), .cfg_en(cfg_en),
    .read_pixel(read_pixel4), .win_id(win_id4), .rd_addr(rd_addr4), .cfg_pending(cfg_pending4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; pulses last one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic cfg(input int idx, input int xl, input int xr, input int yu, input int yd,
                     input bit en, input bit fs);
    cfg_we      = 1'b1;
    cfg_idx     = IW'(idx);
    cfg_xl      = W'(xl);
    cfg_xr      = W'(xr);
    cfg_yu      = W'(yu);
    cfg_yd      = W'(yd);
    cfg_en      = en;
    frame_start = fs;
    step();
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    step();
  endtask

  task automatic pix(input int px, input int py, input bit hit, input int id, input int addr,
                     input bit fs);
    x           = W'(px);
    y           = W'(py);
    pix_valid   = 1'b1;
    frame_start = fs;
    if (hit) begin
      q.push_back('{IW'(id), AW'(addr)});
      if (aw4Phase) q4.push_back('{IW'(id), AW'(addr % 16)});
    end
    step();
  endtask

  always @(negedge clk) begin
    expT e;
    if (read_pixel) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit: got win_id=%0d rd_addr=%0d, want no hit", win_id, rd_addr);
      end else begin
        e = q.pop_front();
        check("win_id", 32'(win_id), 32'(e.id));
        check("rd_addr", 32'(rd_addr), 32'(e.addr));
      end
    end else begin
      check("idle_outputs_zero", 32'({win_id, rd_addr}), 0);
    end
  end

  always @(negedge clk) begin
    expT e;
    if (read_pixel4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit_aw4: got win_id=%0d rd_addr=%0d, want no hit", win_id4, rd_addr4);
      end else begin
        e = q4.pop_front();
        check("win_id_aw4", 32'(win_id4), 32'(e.id));
        check("rd_addr_aw4", 32'(rd_addr4), 32'(e.addr));
      end
    end else begin
      check("idle_outputs_zero_aw4", 32'({win_id4, rd_addr4}), 0);
    end
  end

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0;
    x = '0; y = '0; cfg_idx = '0;
    cfg_xl = '0; cfg_xr = '0; cfg_yu = '0; cfg_yd = '0;
    repeat (2) step();
    check("reset_read_pixel", 32'(read_pixel), 0);
    check("reset_win_id", 32'(win_id), 0);
    check("reset_rd_addr", 32'(rd_addr), 0);
    check("reset_cfg_pending", 32'(cfg_pending), 0);
    rst_n = 1'b1;

    // Unconfigured windows never hit, even after a frame_start.
    pix(0, 0, 0, 0, 0, 0);
    fstart();
    pix(0, 0, 0, 0, 0, 0);

    // Basic hit: window 0 = x 10..20, y 5..8.
    cfg(0, 10, 20, 5, 8, 1, 0);
    check("pending_after_cfg", 32'(cfg_pending), 1);
    fstart();
    check("pending_after_frame_start", 32'(cfg_pending), 0);
    for (int px = 9; px <= 21; px++) pix(px, 5, (px >= 10 && px <= 20), 0, px - 10, 0);
    pix(15, 9, 0, 0, 0, 0);
    pix(15, 4, 0, 0, 0, 0);

    // Priority: overlapping windows, lower index wins; win1 counter starts at x=16.
    cfg(0, 0, 15, 0, 0, 1, 0);
    cfg(1, 10, 30, 0, 0, 1, 0);
    fstart();
    for (int px = 0; px <= 30; px++) begin
      if (px <= 15) pix(px, 0, 1, 0, px, 0);
      else          pix(px, 0, 1, 1, px - 16, 0);
    end

    // Shadow timing and frame_start/hit collisions (win0 at 16, win1 at 15).
    cfg(0, 0, 15, 0, 0, 0, 0);
    check("pending_mid_frame", 32'(cfg_pending), 1);
    pix(5, 0, 1, 0, 16, 0);
    pix(3, 0, 1, 0, 17, 1);
    check("pending_cleared", 32'(cfg_pending), 0);
    pix(3, 0, 0, 0, 0, 0);
    pix(12, 0, 1, 1, 0, 0);
    pix(20, 0, 1, 1, 1, 1);
    pix(21, 0, 1, 1, 0, 0);

    // cfg_we on the frame_start edge is written through and leaves nothing pending.
    cfg(1, 5, 5, 0, 0, 1, 1);
    check("pending_fs_with_cfg", 32'(cfg_pending), 0);
    pix(5, 0, 1, 1, 0, 0);
    pix(6, 0, 0, 0, 0, 0);
    pix(4, 0, 0, 0, 0, 0);
    pix(12, 0, 0, 0, 0, 0);

    // Inverted, degenerate and out-of-range-index windows.
    cfg(0, 20, 10, 0, 0, 1, 0);
    cfg(1, 0, 0, 0, 0, 1, 0);
    fstart();
    cfg(2, 0, 1023, 0, 1023, 1, 0);
    check("pending_ignored_idx", 32'(cfg_pending), 0);
    fstart();
    for (int px = 0; px <= 25; px++) pix(px, 0, (px == 0), 1, 0, 0);
    pix(0, 1, 0, 0, 0, 0);
    pix(15, 5, 0, 0, 0, 0);

    // Reset mid-scan overrides a coincident cfg_we and pixel.
    cfg(0, 0, 100, 3, 3, 1, 0);
    fstart();
    for (int px = 0; px <= 3; px++) pix(px, 3, 1, 0, px, 0);
    rst_n = 1'b0;
    cfg_we = 1'b1; cfg_idx = '0; cfg_xl = '0; cfg_xr = W'(100);
    cfg_yu = W'(3); cfg_yd = W'(3); cfg_en = 1'b1;
    x = W'(4); y = W'(3); pix_valid = 1'b1;
    step();
    check("rst_mid_read_pixel", 32'(read_pixel), 0);
    check("rst_mid_win_id", 32'(win_id), 0);
    check("rst_mid_rd_addr", 32'(rd_addr), 0);
    check("rst_mid_cfg_pending", 32'(cfg_pending), 0);
    rst_n = 1'b1;
    pix(5, 3, 0, 0, 0, 0);
    fstart();
    pix(5, 3, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 0, 0);
    cfg(0, 0, 100, 3, 3, 1, 0);
    fstart();
    pix(5, 3, 1, 0, 0, 0);

    // Counter wrap on the AW=4 instance: 17-pixel window gives 0..15 then 0.
    rst4_n = 1'b1;
    aw4Phase = 1'b1;
    cfg(0, 0, 16, 7, 7, 1, 0);
    cfg(1, 0, 0, 0, 0, 0, 0);
    check("pending_aw4", 32'(cfg_pending4), 1);
    fstart();
    for (int px = 0; px <= 16; px++) pix(px, 7, 1, 0, px, 0);
    pix(17, 7, 0, 0, 0, 0);

    repeat (3) step();
    check("queue_drained", 32'(q.size()), 0);
    check("queue_drained_aw4", 32'(q4.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_window_ctrl.md
PIXEL_WINDOW_CTRL -- requirements
Module: pixel_window_ctrl

Interface
REQ-001 Parameter W, default 10: coordinate width of x, y and all window bounds.
REQ-002 Parameter NWIN, default 2: number of independent display windows (1..8).
REQ-003 Parameter AW, default 17: width of each per-window read-address counter.
REQ-004 Parameter IW, default 3: width of window index ports; SHALL satisfy 2^IW >= NWIN.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 frame_start  input  1  one-cycle pulse at start of frame; loads the active window set.
REQ-008 pix_valid  input  1  the current x,y is a visible pixel.
REQ-009 x  input  W  current horizontal coordinate.
REQ-010 y  input  W  current vertical coordinate.
REQ-011 cfg_we  input  1  write strobe for the shadow window configuration.
REQ-012 cfg_idx  input  IW  window index for cfg_we.
REQ-013 cfg_xl, cfg_xr, cfg_yu, cfg_yd  input  W each  inclusive bounds (left, right, top, bottom).
REQ-014 cfg_en  input  1  enable bit written with the bounds.
REQ-015 read_pixel  output  1  registered hit: the pixel presented one cycle earlier lies in an enabled window.
REQ-016 win_id  output  IW  index of the winning window; 0 when read_pixel=0.
REQ-017 rd_addr  output  AW  frame-buffer read address for the hit; 0 when read_pixel=0.
REQ-018 cfg_pending  output  1  shadow configuration differs from active; cleared by frame_start.

Function
REQ-019 Each window SHALL have shadow registers (xl, xr, yu, yd, en) and active registers of the same fields.
REQ-020 A cfg_we with cfg_idx < NWIN SHALL update that window's shadow registers on the same edge; cfg_idx >= NWIN SHALL be ignored.
REQ-021 A cfg_we with cfg_idx >= NWIN SHALL NOT set cfg_pending.
REQ-022 On frame_start the active registers SHALL be loaded from the shadow registers; a cfg_we on the same edge SHALL be written through, so its value is loaded.
REQ-023 cfg_pending SHALL set on an accepted cfg_we and clear on frame_start; on a simultaneous accepted cfg_we and frame_start it SHALL be 0.
REQ-024 Window k hits when pix_valid=1, active en=1, xl<=x<=xr and yu<=y<=yd, using unsigned W-bit compares.
REQ-025 A window with xl>xr or yu>yd SHALL never hit; there is no wrap-around of bounds.
REQ-026 When several windows hit, the lowest index SHALL win (fixed priority).
REQ-027 Each window SHALL own an AW-bit address counter, cleared to 0 on frame_start.
REQ-028 On a hit by window k, rd_addr SHALL present counter k's pre-increment value, and counter k SHALL increment by 1.
REQ-029 Counters of losing, overlapped windows SHALL NOT increment.
REQ-030 Counters SHALL wrap modulo 2^AW without a flag.
REQ-031 Latency SHALL be exactly one cycle: inputs sampled at edge n appear on read_pixel, win_id and rd_addr after edge n.
REQ-032 If frame_start and pix_valid coincide, the hit SHALL be evaluated against the previously active registers, and the counter SHALL clear to 0 (clear overrides increment); rd_addr SHALL still show the old counter value.
REQ-033 The pixel on the cycle after frame_start SHALL use the newly loaded windows and counter value 0.

Reset
REQ-034 While rst_n=0 at a rising edge, every output SHALL be set to 0.
REQ-035 While rst_n=0 at a rising edge, all shadow and active registers SHALL be set to 0, with en=0.
REQ-036 While rst_n=0 at a rising edge, all address counters SHALL be set to 0.
REQ-037 Reset SHALL override frame_start and cfg_we, including mid-frame; no hit SHALL occur until a window is configured and a frame_start loads it.

Verification
REQ-038 Basic hit: cfg win0 = (10,20,5,8,en=1), frame_start, then scan x=9..21 at y=5 -> read_pixel=1 for x=10..20, rd_addr=0..10, win_id=0, with one-cycle delay.
REQ-039 Priority: win0 = (0,15,0,0), win1 = (10,30,0,0), both enabled; scan y=0, x=0..30 -> win_id=0 for x=0..15 and win_id=1 for x=16..30; win1 rd_addr starts at 0 at x=16.
REQ-040 Shadow timing: mid-frame, write win0 en=0 -> cfg_pending=1 and hits continue; after frame_start -> cfg_pending=0 and no hits.
REQ-041 Boundaries: inverted window (20,10,0,0) -> no hits; degenerate window (x=y=0) -> one hit; AW=4 with a 17-pixel window -> rd_addr 0..15, then 0.
REQ-042 Collisions: frame_start coinciding with a hit -> rd_addr shows the old count and the next hit shows 0; frame_start coinciding with cfg_we -> the new value is active and cfg_pending=0.
REQ-043 Reset mid-scan: rst_n=0 for one cycle during hits -> all outputs 0 on the next cycle and no hits until reconfiguration plus frame_start.
